axis_sync_fifo: RTL and testbench

Parametrised single-clock AXI-Stream FIFO, successor to the basic pointer FIFO. Adds:
- valid/ready handshakes on both sides.
- First-word-fall-through (FWFT) output.
- Full use of DEPTH entries.
- TLAST sideband.
- Occupancy count and programmable almost-full/almost-empty flags.
- Synchronous flush.

Sits between the SERDES byte/word stages and downstream AXIS consumers as the elastic buffer.

---
 rtl/axis_sync_fifo_pkg.sv | 22 ++
 rtl/axis_sync_fifo_mem_2p.sv | 26 ++
 rtl/axis_sync_fifo.sv | 96 +++++++++
 tb/tb_axis_sync_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_sync_fifo_pkg.sv
// Shared sizing helpers for the AXI-Stream sync FIFO and its storage.
// Entries are stored as {tlast, tdata}; parametrised width rules out a package struct.
package axis_fifo_pkg;

  localparam int SIDEBAND_W = 1;

  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2_safe(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return clog2_safe(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_mem_2p.sv
// Storage for axis_sync_fifo: one synchronous write port and one asynchronous read port.
// Read data follows raddr combinationally; no backpressure, contents are never reset.
module fifo_mem_2p
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock FWFT AXI-Stream FIFO with level and almost flags; write-to-output latency 1 cycle.
// Backpressure: registered s_axis_tready drops when full; head word held while m_axis_tready is low.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [DWIDTH-1:0]            s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DWIDTH-1:0]            m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [lvl_w(DEPTH)-1:0]      level,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int WW = DWIDTH + SIDEBAND_W;

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt;
  logic [LW-1:0] level_nxt;
  logic          push, pop;
  logic          full_nxt, empty_nxt;
  logic [WW-1:0] rd_word;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_comb begin
    wptr_nxt  = wptr + PW'(push);
    rptr_nxt  = rptr + PW'(pop);
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
    // Wrap bit distinguishes full from empty when the index bits coincide.
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
    end else if (flush) begin
      rptr          <= wptr;
      level         <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      level         <= level_nxt;
      m_axis_tvalid <= !empty_nxt;
      s_axis_tready <= !full_nxt;
      almost_full   <= (level_nxt >= LW'(AFULL_LVL));
      almost_empty  <= (level_nxt <= LW'(AEMPTY_LVL));
    end
  end

  fifo_mem_2p #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wptr[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign {m_axis_tlast, m_axis_tdata} = rd_word;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo: stimulus queues expected words, a negedge monitor checks.
module tb_axis_sync_fifo;

  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 14;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [4:0]    level;
  logic          almost_full;
  logic          almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] sb_q[$];
  logic        pend_push = 1'b0;
  logic        exp_rdy   = 1'b0;
  int          lvl;
  logic        hold_vld  = 1'b0;
  logic [DW:0] hold_word;

  axis_sync_fifo #(
    .DWIDTH     (DW),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL),
    .AEMPTY_LVL (AEMPTY)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .level         (level),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: expected occupancy is the scoreboard depth minus any word still in flight.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_afull", 64'(almost_full), 64'd0);
      chk("rst_aempty", 64'(almost_empty), 64'd1);
      hold_vld = 1'b0;
    end else begin
      lvl = sb_q.size() - (pend_push ? 1 : 0);
      chk("level", 64'(level), 64'(lvl));
      chk("tvalid", 64'(m_tvalid), 64'(lvl != 0));
      chk("tready", 64'(s_tready), 64'(exp_rdy));
      chk("afull", 64'(almost_full), 64'(lvl >= AFULL));
      chk("aempty", 64'(almost_empty), 64'(lvl <= AEMPTY));
      if (hold_vld && m_tvalid)
        chk("hold", 64'({m_tlast, m_tdata}), 64'(hold_word));
      hold_vld  = m_tvalid && !m_tready && !flush;
      hold_word = {m_tlast, m_tdata};
      if (flush) begin
        sb_q.delete();
      end else if (m_tvalid && m_tready && lvl > 0) begin
        chk("data", 64'({m_tlast, m_tdata}), 64'(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input logic vld, input logic [DW-1:0] d, input logic l,
                       input logic mr, input logic fl);
    @(posedge clk);
    #1;
    exp_rdy   = (sb_q.size() < DEPTH);
    s_tvalid  = vld;
    s_tdata   = d;
    s_tlast   = l;
    m_tready  = mr;
    flush     = fl;
    pend_push = vld && exp_rdy && !fl;
    if (pend_push) sb_q.push_back({l, d});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn      = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b0;
    flush     = 1'b0;
    sb_q.delete();
    pend_push = 1'b0;
    exp_rdy   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    @(negedge clk);
    chk("tready_before_edge", 64'(s_tready), 64'd0);
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    chk("tready_after_edge", 64'(s_tready), 64'd1);
    chk("idle_aempty", 64'(almost_empty), 64'd1);
    drive(0, '0, 0, 0, 0);

    // Fill to full, then offer a word that must be refused
    for (int i = 1; i <= DEPTH; i++) drive(1, DW'(i), (i % 4) == 0, 0, 0);
    drive(1, 32'hBAD, 0, 0, 0);
    @(negedge clk);
    chk("full_level", 64'(level), 64'd16);
    chk("full_tready", 64'(s_tready), 64'd0);
    chk("full_afull", 64'(almost_full), 64'd1);
    chk("full_head", 64'(m_tdata), 64'h1);

    // Drain in order
    drive(0, '0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 0, 1, 0);
    @(negedge clk);
    chk("drained_tvalid", 64'(m_tvalid), 64'd0);
    chk("drained_aempty", 64'(almost_empty), 64'd1);

    // Steady push+pop at level 5, wrapping pointers
    for (int i = 0; i < 5; i++) drive(1, 32'h200 + DW'(i), 0, 0, 0);
    for (int i = 0; i < 40; i++) drive(1, 32'h300 + DW'(i), (i % 3) == 0, 1, 0);
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    chk("steady_level", 64'(level), 64'd5);

    // Full plus pop with s_tvalid held high
    for (int i = 0; i < 11; i++) drive(1, 32'h400 + DW'(i), 0, 0, 0);
    drive(1, 32'h77, 1, 1, 0);
    @(negedge clk);
    chk("fullpop_level_before", 64'(level), 64'd16);
    drive(1, 32'h77, 1, 0, 0);
    @(negedge clk);
    chk("fullpop_level", 64'(level), 64'd15);
    chk("fullpop_tready", 64'(s_tready), 64'd1);
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    chk("refill_level", 64'(level), 64'd16);

    // Flush with a concurrent push at level 7
    for (int i = 0; i < 9; i++) drive(0, '0, 0, 1, 0);
    drive(1, 32'hDEAD, 1, 0, 1);
    @(negedge clk);
    chk("preflush_level", 64'(level), 64'd7);
    drive(1, 32'h55, 0, 0, 0);
    @(negedge clk);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_tvalid", 64'(m_tvalid), 64'd0);
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    chk("postflush_tvalid", 64'(m_tvalid), 64'd1);
    chk("postflush_data", 64'(m_tdata), 64'h55);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 0);

    // Random traffic: fill-biased then drain-biased, with occasional flush
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 59) == 0);

    // Reset in mid-transfer
    for (int i = 0; i < 4; i++) drive(1, $urandom, 0, 0, 0);
    do_reset();
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 0);
    @(negedge clk);
    chk("post_reset_level", 64'(level), 64'd0);
    chk("post_reset_tready", 64'(s_tready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
